// File: rtl/lsu_wb_pkg.sv
// lsu_wb_pkg: shared definitions for the LSU Wishbone initiator.
//   - state_t     : FSM encoding for lsu_wb_master
//   - F3_*        : RV32 load/store width codes (funct3)
//   - sel_for     : byte-select pattern for a width at a byte offset
//   - lane_shift  : moves right-justified store data into its byte lanes
package lsu_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal codes fall through to a full-word pattern; they never reach the bus.
    function automatic logic [3:0] sel_for(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3)
            F3_B, F3_BU: s = 4'b0001 << a;
            F3_H, F3_HU: s = 4'b0011 << a;
            default:     s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] a);
        return d << {a, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_wb_align.sv
// lsu_wb_align: purely combinational data-path helpers for lsu_wb_master.
// Request side (from the CPU, evaluated in IDLE):
//   req_funct3_i, req_we_i, req_lsb_i, req_wdata_i -> lane_data_o, sel_o, bad_o
//   bad_o = misaligned access or illegal width code (no bus cycle is issued).
// Load side (from the bus, evaluated in ACCESS):
//   ld_funct3_i, ld_raw_i -> ld_data_o (sign/zero extended, raw is right-justified).
module lsu_wb_align
    import lsu_wb_pkg::*;
(
    input  logic [2:0]  req_funct3_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_lsb_i,
    input  logic [31:0] req_wdata_i,
    output logic [31:0] lane_data_o,
    output logic [3:0]  sel_o,
    output logic        bad_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic illegal;
    logic misaligned;

    assign lane_data_o = lane_shift(req_wdata_i, req_lsb_i);
    assign sel_o       = sel_for(req_funct3_i, req_lsb_i);
    assign bad_o       = illegal | misaligned;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (req_funct3_i)
            F3_B:  illegal = 1'b0;
            // Unsigned widths only exist for loads.
            F3_BU: illegal = req_we_i;
            F3_H:  misaligned = req_lsb_i[0];
            F3_HU: begin
                illegal    = req_we_i;
                misaligned = req_lsb_i[0];
            end
            F3_W:  misaligned = |req_lsb_i;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ld_data_o = ld_raw_i;
        case (ld_funct3_i)
            F3_B:  ld_data_o = {{24{ld_raw_i[7]}}, ld_raw_i[7:0]};
            F3_BU: ld_data_o = {24'd0, ld_raw_i[7:0]};
            F3_H:  ld_data_o = {{16{ld_raw_i[15]}}, ld_raw_i[15:0]};
            F3_HU: ld_data_o = {16'd0, ld_raw_i[15:0]};
            default: ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: Wishbone classic single-access initiator for the CPU LSU.
// One RV32 load/store at a time: IDLE -> ACCESS -> RESP (or IDLE -> RESP
// directly when the request is misaligned or has an illegal width).
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we/addr/wdata/funct3    request payload
//   resp_valid/rdata/err        one-cycle completion pulse with result
//   wb_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o   Wishbone master outputs (registered)
//   wb_dat_i/ack_i/err_i        Wishbone slave returns
// Parameter TIMEOUT_CYCLES (1..65535): ACCESS cycle limit.
// Build option: define WB_TIMEOUT_EN to abort an unanswered access after
// TIMEOUT_CYCLES cycles with resp_err=1; otherwise ACCESS waits forever.
module lsu_wb_master
    import lsu_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("lsu_wb_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] lane_data;
    logic [3:0]  lane_sel;
    logic        req_bad;
    logic [31:0] ld_data;

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          expire;

    // cnt_inc is the number of ACCESS cycles including the current one, so
    // expiry fires in the TIMEOUT_CYCLES-th cycle.
    assign cnt_inc = cnt_q + CW'(1);
    assign expire  = (cnt_inc == TO_VAL);
`endif

    lsu_wb_align u_align (
        .req_funct3_i (req_funct3),
        .req_we_i     (req_we),
        .req_lsb_i    (req_addr[1:0]),
        .req_wdata_i  (req_wdata),
        .lane_data_o  (lane_data),
        .sel_o        (lane_sel),
        .bad_o        (req_bad),
        .ld_funct3_i  (f3_q),
        .ld_raw_i     (wb_dat_i),
        .ld_data_o    (ld_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign wb_cyc_o   = (state_q == ST_ACCESS);
    assign wb_stb_o   = (state_q == ST_ACCESS);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    adr_d = req_addr;
                    dat_d = lane_data;
                    sel_d = lane_sel;
                    f3_d  = req_funct3;
                    if (req_bad) begin
                        // Rejected before touching the bus.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
`ifdef WB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
`ifdef WB_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                // Error beats a simultaneous ack; either beats a timeout.
                if (wb_err_i) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else if (wb_ack_i) begin
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : ld_data;
                    state_d = ST_RESP;
                end
`ifdef WB_TIMEOUT_EN
                else if (expire) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                // Result is only meaningful during the pulse.
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/lsu_wb_master.md
# lsu_wb_master

Wishbone classic single-access initiator bridging the CPU load/store stage to the SoC data bus (instruction memory read port, peripherals). Accepts one RV32 load/store request at a time and drives byte lanes and select bits. Sign/zero-extends load data and reports bus errors, misalignment and illegal widths.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in ACCESS before abort (WB_TIMEOUT_EN only); legal range 1..65535.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: bus error, timeout, misaligned or illegal width.
- wb_cyc_o, wb_stb_o  out  1 each  asserted together for the whole access.
- wb_we_o  out  1  copy of req_we.
- wb_adr_o  out  32  full byte address, stable while wb_cyc_o high.
- wb_dat_o  out  32  store data shifted into lanes by addr[1:0].
- wb_sel_o  out  4  byte selects: B 0001<<a, H 0011<<a, W 1111.
- wb_dat_i  in  32  read data, right-justified by slave (byte at wb_adr_o in bits 7:0).
- wb_ack_i, wb_err_i  in  1 each  cycle termination.

## Operation
- States IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On accept, register addr/we/funct3/lane-shifted data/sel. Legal -> ACCESS. Misaligned (H with a[0]=1, W with a[1:0]!=0) or illegal funct3 (011, 110, 111; 100/101 with we=1) -> RESP with err=1, no bus cycle.
- ACCESS: cyc=stb=1. On sampled wb_err_i -> RESP err=1. Else on wb_ack_i -> RESP, capture wb_dat_i. wb_err_i overrides simultaneous wb_ack_i.
- RESP: cyc=stb=0, resp_valid=1 for exactly one cycle, then IDLE.
- Load extension from wb_dat_i bit 0: B sign-extends bit 7, H bit 15, BU/HU zero-extend, W passthrough.
- Reset values: state IDLE; all outputs 0 except req_ready=1 after first reset cycle; resp_valid=0.
- Reset mid-ACCESS: cyc/stb drop at the reset edge; no response is ever issued for the aborted request.
- Spurious wb_ack_i/wb_err_i outside ACCESS ignored.

## Timing
- Accept at edge N; cyc/stb high from N+1 (registered outputs).
- Registered slave acking one cycle after stb: ack sampled at edge N+2; resp_valid in cycle N+2..N+3, cyc/stb low in the same cycle.
- Zero-wait ack (ack in first ACCESS cycle) supported: resp_valid one cycle after cyc/stb rise.
- Error-before-bus: resp_valid in the cycle after accept.
- Minimum 3 cycles per access; req_ready low from accept through RESP.

## Configuration
- WB_TIMEOUT_EN defined: counter width $clog2(TIMEOUT_CYCLES+1), cleared on entering ACCESS, increments each ACCESS cycle; when it equals TIMEOUT_CYCLES with no ack/err sampled, go to RESP with err=1, rdata=0. Ack/err on the expiry cycle wins over timeout.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES ignored.

## Structure
- Shared package lsu_wb_pkg: state enum, funct3 width localparams, sel/lane-shift helper functions.
- Sub-module lsu_wb_align: combinational store-lane placement, sel generation, misalign/illegal detection, load extension; FSM and counter stay in top.

## Test plan
- LW 0x0000_0010, slave acks next cycle with 0xDEAD_BEEF -> resp_rdata 0xDEAD_BEEF, err 0, resp_valid exactly cycle N+3 relative to accept N.
- SB addr 0x...03, wdata 0x0000_00A5 -> wb_sel_o 1000, wb_dat_o 0xA500_0000, wb_we_o 1; LB same addr with wb_dat_i 0x0000_0080 -> 0xFFFF_FF80, LBU -> 0x0000_0080.
- LH addr 0x...01 and funct3 011 -> resp_err 1 one cycle after accept, wb_cyc_o never asserts.
- wb_err_i and wb_ack_i both high in ACCESS -> resp_err 1, rdata 0; ack/err pulses while IDLE -> no resp_valid.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave silent -> abort after 4 ACCESS cycles, resp_err 1; ack on 4th cycle -> normal completion.
- rst_n low during ACCESS -> cyc/stb 0 next edge, no resp_valid; new LW after reset completes normally.
